execute_sequencer: RTL

//  Execute-stage controller for one issued RV32I instruction. Latches the decoded instruction and operands, then drives

---
 rtl/execute_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/execute_sequencer.sv
// Execute-stage sequencer for one issued RV32I instruction: dispatches to the
// combinational ALU or an iterative unit, then holds the result on writeback.
module execute_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [6:0]  issue_opcode,
    input  logic [2:0]  issue_funct3,
    input  logic [6:0]  issue_funct7,
    input  logic [31:0] issue_imm,
    input  logic [31:0] issue_pc,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_rs1_val,
    input  logic [31:0] issue_rs2_val,
    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [31:0] alu_rs1_val,
    output logic [31:0] alu_rs2_val,
    output logic        alu_read_valid,
    input  logic        alu_processing,
    input  logic        alu_valid,
    input  logic [31:0] alu_rd_val,
    output logic        iter_start,
    input  logic        iter_accept,
    output logic        iter_abort,
    input  logic        iter_done,
    input  logic [31:0] iter_rd_val,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_val,
    output logic [1:0]  wb_err,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT_ITER,
        S_WB
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_UNKNOWN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        wb_val_q, wb_val_d;
    logic [1:0]         wb_err_q, wb_err_d;
    logic [31:0]        retired_q, retired_d;
    logic               load_issue;

    logic [6:0]         opcode_q, funct7_q;
    logic [2:0]         funct3_q;
    logic [31:0]        imm_q, pc_q, rs1_q, rs2_q;
    logic [4:0]         rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wb_val_q  <= '0;
            wb_err_q  <= ERR_OK;
            retired_q <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_val_q  <= wb_val_d;
            wb_err_q  <= wb_err_d;
            retired_q <= retired_d;
            if (load_issue) begin
                opcode_q <= issue_opcode;
                funct3_q <= issue_funct3;
                funct7_q <= issue_funct7;
                imm_q    <= issue_imm;
                pc_q     <= issue_pc;
                rd_q     <= issue_rd;
                rs1_q    <= issue_rs1_val;
                rs2_q    <= issue_rs2_val;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wb_val_d       = wb_val_q;
        wb_err_d       = wb_err_q;
        retired_d      = retired_q;
        load_issue     = 1'b0;
        alu_read_valid = 1'b0;
        iter_start     = 1'b0;
        iter_abort     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    load_issue = 1'b1;
                    state_d    = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                alu_read_valid = 1'b1;
                iter_start     = !alu_processing;
                if (alu_valid) begin
                    wb_val_d = alu_rd_val;
                    wb_err_d = ERR_OK;
                    state_d  = S_WB;
                end else if (iter_start && iter_accept) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_ITER;
                end else begin
                    wb_val_d = '0;
                    wb_err_d = ERR_UNKNOWN;
                    state_d  = S_WB;
                end
            end
            S_WAIT_ITER: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving on the last allowed cycle still counts as success.
                if (iter_done) begin
                    wb_val_d = iter_rd_val;
                    wb_err_d = ERR_OK;
                    state_d  = S_WB;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    wb_val_d = '0;
                    wb_err_d = ERR_TIMEOUT;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush drops everything in flight; only an op the iterative unit owns needs an abort.
        if (flush) begin
            state_d    = S_IDLE;
            cnt_d      = cnt_q;
            wb_val_d   = wb_val_q;
            wb_err_d   = wb_err_q;
            retired_d  = retired_q;
            load_issue = 1'b0;
            iter_abort = !reset && ((state_q == S_WAIT_ITER) ||
                                    ((state_q == S_DISPATCH) && iter_start && iter_accept));
        end
    end

    assign issue_ready = (state_q == S_IDLE);
    assign wb_valid    = (state_q == S_WB);
    assign wb_rd       = rd_q;
    assign wb_val      = wb_val_q;
    assign wb_err      = wb_err_q;
    assign wb_we       = wb_valid && (rd_q != 5'd0) && (wb_err_q == ERR_OK);
    assign retired_cnt = retired_q;

    assign alu_opcode  = opcode_q;
    assign alu_funct3  = funct3_q;
    assign alu_funct7  = funct7_q;
    assign alu_imm     = imm_q;
    assign alu_pc      = pc_q;
    assign alu_rs1_val = rs1_q;
    assign alu_rs2_val = rs2_q;

endmodule
